// File: rtl/bin_npu_pkg.sv
// Shared types for the binary NPU datapath: mask mode, MAC FSM states and
// accumulator sizing.
package bin_npu_pkg;

  typedef enum logic {
    MODE_AND  = 1'b0,
    MODE_XNOR = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Wide enough for SIZE*MAX_LEN, so a full group can never wrap.
  function automatic int unsigned acc_width(input int unsigned size,
                                            input int unsigned max_len);
    return $clog2(size * max_len + 1);
  endfunction

endpackage

// File: rtl/bin_mac_popcnt_popcnt.sv
// Combinational population count built as a recursive binary adder tree.
module popcnt #(
  parameter  int unsigned SIZE  = 128,
  localparam int unsigned CNT_W = $clog2(SIZE + 1)
) (
  input  logic [SIZE-1:0]  vec,
  output logic [CNT_W-1:0] count
);

  if (SIZE == 1) begin : g_leaf
    assign count = vec;
  end else begin : g_split
    localparam int unsigned LO   = SIZE / 2;
    localparam int unsigned HI   = SIZE - LO;
    localparam int unsigned LO_W = $clog2(LO + 1);
    localparam int unsigned HI_W = $clog2(HI + 1);

    logic [LO_W-1:0] lo_cnt;
    logic [HI_W-1:0] hi_cnt;

    popcnt #(.SIZE(LO)) u_lo (.vec(vec[LO-1:0]),   .count(lo_cnt));
    popcnt #(.SIZE(HI)) u_hi (.vec(vec[SIZE-1:LO]), .count(hi_cnt));

    assign count = CNT_W'(lo_cnt) + CNT_W'(hi_cnt);
  end

endmodule

// File: rtl/bin_mac_popcnt.sv
// Binary MAC: masks IFM against filter (AND / XNOR), popcounts each beat and
// accumulates a programmable number of beats into one partial sum.
module bin_mac_popcnt
  import bin_npu_pkg::*;
#(
  parameter int unsigned SIZE    = 128,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned ACC_W   = acc_width(SIZE, MAX_LEN)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mode_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [SIZE-1:0]  IFM_i,
  input  logic [SIZE-1:0]  filter_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [ACC_W-1:0] sum_o
);

  localparam int unsigned PC_W = $clog2(SIZE + 1);

  state_t           state, state_next;
  mode_t            mode_q, mode_cur;
  logic [LEN_W-1:0] len_q, len_in_eff, len_cur, cnt, cnt_inc;
  logic             accept, last_beat;
  logic [SIZE-1:0]  masked, s1_vec;
  logic             s1_valid, s1_first, s1_last;
  logic [PC_W-1:0]  pc;
  logic [ACC_W-1:0] acc;

  always_comb begin
    len_in_eff = len_i;
    if (len_i == '0)                      len_in_eff = LEN_W'(1);
    else if (len_i > LEN_W'(MAX_LEN))     len_in_eff = LEN_W'(MAX_LEN);
  end

  assign ready_o = (state == IDLE) || (state == ACC);
  assign accept  = valid_i && ready_o;

  // First beat of a group uses the live mode/len; later beats use the latched copies.
  always_comb begin
    mode_cur  = (state == IDLE) ? mode_t'(mode_i) : mode_q;
    len_cur   = (state == IDLE) ? len_in_eff : len_q;
    cnt_inc   = (state == IDLE) ? LEN_W'(1) : cnt + LEN_W'(1);
    last_beat = (cnt_inc == len_cur);
    masked    = (mode_cur == MODE_XNOR) ? ~(IFM_i ^ filter_i) : (IFM_i & filter_i);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = last_beat ? DRAIN : ACC;
      ACC:     if (accept && last_beat) state_next = DRAIN;
      DRAIN:   state_next = OUT;
      OUT:     if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      mode_q <= MODE_AND;
      len_q  <= '0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt <= cnt_inc;
        if (state == IDLE) begin
          mode_q <= mode_cur;
          len_q  <= len_in_eff;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_vec   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_vec   <= masked;
        s1_first <= (state == IDLE);
        s1_last  <= last_beat;
      end
    end
  end

  popcnt #(.SIZE(SIZE)) u_popcnt (.vec(s1_vec), .count(pc));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc     <= '0;
      sum_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      if (s1_valid) begin
        if (s1_last) begin
          sum_o   <= (s1_first ? '0 : acc) + ACC_W'(pc);
          acc     <= '0;
          valid_o <= 1'b1;
        end else begin
          acc <= (s1_first ? '0 : acc) + ACC_W'(pc);
        end
      end else if ((state == OUT) && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bin_mac_popcnt.sv
// Randomised bench for bin_mac_popcnt against a per-group popcount model.
module tb_bin_mac_popcnt;

  localparam int unsigned SIZE    = 128;
  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned ACC_W   = $clog2(SIZE * MAX_LEN + 1);

  logic             clk_i;
  logic             rst_ni;
  logic             mode_i;
  logic [LEN_W-1:0] len_i;
  logic             valid_i;
  logic             ready_o;
  logic [SIZE-1:0]  IFM_i;
  logic [SIZE-1:0]  filter_i;
  logic             valid_o;
  logic             ready_i;
  logic [ACC_W-1:0] sum_o;

  bin_mac_popcnt #(
    .SIZE(SIZE),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .len_i(len_i),
    .valid_i(valid_i), .ready_o(ready_o), .IFM_i(IFM_i), .filter_i(filter_i),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks;
  int n_pass;

  logic [SIZE-1:0] ifm_q[$];
  logic [SIZE-1:0] flt_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // AND counts bits set in both; XNOR counts bit positions that agree.
  function automatic int beat_pc(input logic m, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    if (m) return SIZE - $countones(a ^ b);
    return $countones(a & b);
  endfunction

  function automatic logic [SIZE-1:0] ones(input int n);
    logic [SIZE-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [SIZE-1:0] rand_vec();
    logic [SIZE-1:0] v;
    for (int w = 0; w < SIZE / 32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic push(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    ifm_q.push_back(a);
    flt_q.push_back(b);
  endtask

  // Drives the queued beats as one group (queue length = effective group length)
  // and checks latency, result, stall stability and the handshake.
  task automatic run_group(input logic m, input int len, input int gap, input int stall,
                           input bit twiddle, input string tag);
    int exp_sum;
    int n;
    int lat;
    exp_sum = 0;
    n = ifm_q.size();
    for (int i = 0; i < n; i++) exp_sum += beat_pc(m, ifm_q[i], flt_q[i]);
    ready_i = (stall == 0);
    for (int i = 0; i < n; i++) begin
      check({tag, "_rdy"}, ready_o, 1);
      valid_i  = 1'b1;
      IFM_i    = ifm_q[i];
      filter_i = flt_q[i];
      mode_i   = (i == 0 || !twiddle) ? m : ~m;
      len_i    = (i == 0 || !twiddle) ? LEN_W'(len) : LEN_W'($urandom());
      @(negedge clk_i);
      valid_i = 1'b0;
      if (i != n - 1) repeat (gap) @(negedge clk_i);
    end
    lat = 1;
    while (!valid_o && lat < 8) begin
      @(negedge clk_i);
      lat++;
    end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_sum"}, sum_o, exp_sum);
    check({tag, "_busy"}, ready_o, 0);
    for (int s = 0; s < stall; s++) begin
      valid_i  = 1'b1;
      IFM_i    = rand_vec();
      filter_i = rand_vec();
      @(negedge clk_i);
      check({tag, "_hold_v"}, valid_o, 1);
      check({tag, "_hold_s"}, sum_o, exp_sum);
      check({tag, "_hold_r"}, ready_o, 0);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    check({tag, "_hs_v"}, valid_o, 0);
    check({tag, "_hs_r"}, ready_o, 1);
    ifm_q.delete();
    flt_q.delete();
  endtask

  initial begin
    logic [SIZE-1:0] a;
    bit seen;
    int len;
    int n;
    n_checks = 0;
    n_pass   = 0;
    rst_ni   = 1'b0;
    mode_i   = 1'b0;
    len_i    = '0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    IFM_i    = '0;
    filter_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_rdy", ready_o, 1);
    check("rst_vld", valid_o, 0);
    check("rst_sum", sum_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    push(ones(SIZE), ones(8));
    run_group(1'b0, 1, 0, 2, 1'b0, "and1");

    for (int i = 0; i < 4; i++) begin
      a = rand_vec();
      push(a, a);
    end
    run_group(1'b1, 4, 0, 0, 1'b0, "xnor_eq");
    for (int i = 0; i < 4; i++) begin
      a = rand_vec();
      push(a, ~a);
    end
    run_group(1'b1, 4, 0, 0, 1'b0, "xnor_inv");

    push(ones(10), ones(SIZE));
    push(ones(20), ones(SIZE));
    push(ones(30), ones(SIZE));
    run_group(1'b0, 3, 2, 0, 1'b0, "gaps");

    for (int i = 0; i < 3; i++) push(rand_vec(), rand_vec());
    run_group(1'b0, 3, 0, 5, 1'b0, "bp");
    for (int i = 0; i < 2; i++) push(rand_vec(), rand_vec());
    run_group(1'b1, 2, 0, 0, 1'b0, "after_bp");

    push(ones(SIZE), ones(SIZE));
    run_group(1'b0, 0, 0, 0, 1'b1, "len0");
    for (int i = 0; i < MAX_LEN; i++) push(ones(SIZE), ones(SIZE));
    run_group(1'b0, MAX_LEN + 5, 0, 1, 1'b1, "lensat");

    // Abort a 4-beat group after two beats.
    ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid_i  = 1'b1;
      mode_i   = 1'b0;
      len_i    = LEN_W'(4);
      IFM_i    = rand_vec();
      filter_i = rand_vec();
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    rst_ni  = 1'b0;
    #1;
    check("mid_rst_rdy", ready_o, 1);
    check("mid_rst_vld", valid_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      seen |= valid_o;
    end
    check("mid_rst_quiet", seen, 0);
    push(ones(5), ones(SIZE));
    push(ones(7), ones(SIZE));
    run_group(1'b0, 2, 0, 0, 1'b0, "post_rst");

    for (int g = 0; g < 20; g++) begin
      len = $urandom_range(0, MAX_LEN + 5);
      n = (len == 0) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
      for (int i = 0; i < n; i++) push(rand_vec(), rand_vec());
      run_group(1'($urandom_range(0, 1)), len, $urandom_range(0, 2),
                $urandom_range(0, 3), 1'b1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
